// File: rtl/score_uart_pkg.sv
// rtl/score_uart_pkg.sv - shared encodings, ASCII constants and baud derivation for score_uart_tx
package score_uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_t;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_QMARK = 8'h3F;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;

  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

  // Out-of-range digits print as '?' rather than wrapping into punctuation.
  function automatic logic [7:0] digit_ascii(input logic [3:0] d);
    return (d <= 4'd9) ? (ASCII_ZERO + {4'd0, d}) : ASCII_QMARK;
  endfunction

endpackage

// File: rtl/score_uart_tx_if.sv
// rtl/score_uart_tx_if.sv - score inputs, send request and serial outputs of score_uart_tx
interface score_uart_tx_if;
  logic [3:0] tens;
  logic [3:0] ones;
  logic       send;
  logic       tx;
  logic       busy;

  modport master (output tens, ones, send, input tx, busy);
  modport slave  (input tens, ones, send, output tx, busy);
endinterface

// File: rtl/uart_tx_byte.sv
// rtl/uart_tx_byte.sv - 8N1 byte serializer; load is accepted when idle or in the done cycle
module uart_tx_byte
  import score_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] data,
  output logic       done,
  output logic       tx
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  tx_state_t     state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          tx_q, tx_d;
  logic          bit_end;

  assign bit_end = (baud_q == BAUD_LAST);
  assign tx      = tx_q;

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (load) begin
          state_d = ST_START;
          baud_d  = '0;
          shreg_d = data;
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_d = ST_DATA;
          baud_d  = '0;
          bit_d   = 3'd0;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          baud_d  = '0;
          shreg_d = {1'b0, shreg_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = ST_STOP;
            bit_d   = 3'd0;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          done   = 1'b1;
          baud_d = '0;
          // A load here chains the next start bit with no idle gap.
          if (load) begin
            state_d = ST_START;
            shreg_d = data;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    tx_d = 1'b1;
    if (state_d == ST_START)     tx_d = 1'b0;
    else if (state_d == ST_DATA) tx_d = shreg_d[0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= 3'd0;
      shreg_q <= 8'h00;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: rtl/score_uart_tx.sv
// rtl/score_uart_tx.sv - sends "<tens><ones>\r\n" on score change or send, with one pending slot
module score_uart_tx
  import score_uart_pkg::*;
#(
  parameter int CLK_HZ = 50000000,
  parameter int BAUD   = 115200
) (
  input  logic            clk,
  input  logic            rst_n,
  score_uart_tx_if.slave  sif
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);

  logic       busy_q, pending_q;
  logic [1:0] idx_q;
  logic [3:0] snap_ones_q;
  logic [7:0] last_q;
  logic [7:0] score;
  logic       trig, byte_done, msg_end, start_msg, next_byte, load;
  logic [7:0] load_data;
  logic       tx_w;

  assign score     = {sif.tens, sif.ones};
  assign trig      = sif.send | (score != last_q);
  assign msg_end   = busy_q & byte_done & (idx_q == 2'd3);
  assign start_msg = (~busy_q & trig) | (msg_end & (pending_q | trig));
  assign next_byte = busy_q & byte_done & (idx_q != 2'd3);
  assign load      = start_msg | next_byte;

  // The tens digit goes straight into the serializer at message start, so only
  // the ones digit needs to be held for the second byte.
  always_comb begin
    load_data = ASCII_LF;
    if (start_msg) begin
      load_data = digit_ascii(sif.tens);
    end else begin
      case (idx_q)
        2'd0:    load_data = digit_ascii(snap_ones_q);
        2'd1:    load_data = ASCII_CR;
        default: load_data = ASCII_LF;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q      <= 1'b0;
      pending_q   <= 1'b0;
      idx_q       <= 2'd0;
      snap_ones_q <= 4'd0;
      last_q      <= 8'h00;
    end else if (start_msg) begin
      busy_q      <= 1'b1;
      pending_q   <= 1'b0;
      idx_q       <= 2'd0;
      snap_ones_q <= sif.ones;
      last_q      <= score;
    end else begin
      if (msg_end) begin
        busy_q <= 1'b0;
        idx_q  <= 2'd0;
      end else if (next_byte) begin
        idx_q <= idx_q + 2'd1;
      end
      if (busy_q && trig) pending_q <= 1'b1;
    end
  end

  uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_byte (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .data  (load_data),
    .done  (byte_done),
    .tx    (tx_w)
  );

  assign sif.tx   = tx_w;
  assign sif.busy = busy_q;

endmodule
